// File: rtl/seq_datapath.sv
// Register-file datapath with a built-in five-state micro-sequencer: one start pulse
// reads Rn into A, reads Rm into B, runs shift/ALU into C, and writes back to Rd.
module seq_datapath #(
    parameter  int WIDTH = 16,
    parameter  int NREGS = 8,
    parameter  int IMM_W = 8,
    parameter  int PC_W  = 8,
    localparam int AW    = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [AW-1:0]    rn,
    input  logic [AW-1:0]    rm,
    input  logic [AW-1:0]    rd,
    input  logic [1:0]       shift,
    input  logic [1:0]       aluop,
    input  logic             asel,
    input  logic             bsel,
    input  logic             setflags,
    input  logic [1:0]       wb_sel,
    input  logic             wb_en,
    input  logic [IMM_W-1:0] imm,
    input  logic [WIDTH-1:0] mdata,
    input  logic [PC_W-1:0]  pc,
    input  logic [AW-1:0]    dbg_addr,
    output logic             busy,
    output logic             done,
    output logic [2:0]       stat,
    output logic [WIDTH-1:0] datapath_out,
    output logic [WIDTH-1:0] dbg_data
);

    localparam logic [AW:0] NREGS_W = (AW + 1)'(NREGS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RDA,
        S_RDB,
        S_EXEC,
        S_WB
    } state_t;

    typedef enum logic [1:0] {
        SH_NONE = 2'b00,
        SH_LSL1 = 2'b01,
        SH_LSR1 = 2'b10,
        SH_ASR1 = 2'b11
    } shift_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_NOT = 2'b11
    } aluop_t;

    typedef enum logic [1:0] {
        WB_MDATA = 2'b00,
        WB_IMM   = 2'b01,
        WB_PC    = 2'b10,
        WB_C     = 2'b11
    } wb_sel_t;

    // Every control field of one operation, captured together on the accepted start.
    typedef struct packed {
        logic [AW-1:0]    rn;
        logic [AW-1:0]    rm;
        logic [AW-1:0]    rd;
        shift_t           shift;
        aluop_t           aluop;
        logic             asel;
        logic             bsel;
        logic             setflags;
        wb_sel_t          wb_sel;
        logic             wb_en;
        logic [IMM_W-1:0] imm;
    } ctrl_t;

    state_t           state_q, state_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [2:0]       stat_q, stat_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];

    logic [WIDTH-1:0] rdata_a;
    logic [WIDTH-1:0] rdata_b;
    logic [WIDTH-1:0] imm_sext;
    logic [WIDTH-1:0] pc_zext;
    logic [WIDTH-1:0] b_shifted;
    logic [WIDTH-1:0] a_op;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH-1:0] alu_res;
    logic             alu_v;
    logic [2:0]       alu_flags;
    logic [WIDTH-1:0] wb_data;
    logic             wb_fire;

    function automatic logic idx_valid(input logic [AW-1:0] idx);
        return {1'b0, idx} < NREGS_W;
    endfunction

    // Indices past the last register read as zero.
    assign rdata_a  = idx_valid(ctrl_q.rn) ? regs_q[ctrl_q.rn] : '0;
    assign rdata_b  = idx_valid(ctrl_q.rm) ? regs_q[ctrl_q.rm] : '0;
    assign dbg_data = idx_valid(dbg_addr)  ? regs_q[dbg_addr]  : '0;

    assign imm_sext = WIDTH'($signed(ctrl_q.imm));
    assign pc_zext  = WIDTH'(pc);

    always_comb begin
        unique case (ctrl_q.shift)
            SH_NONE: b_shifted = b_q;
            SH_LSL1: b_shifted = {b_q[WIDTH-2:0], 1'b0};
            SH_LSR1: b_shifted = {1'b0, b_q[WIDTH-1:1]};
            SH_ASR1: b_shifted = {b_q[WIDTH-1], b_q[WIDTH-1:1]};
            default: b_shifted = b_q;
        endcase
    end

    assign a_op = ctrl_q.asel ? '0 : a_q;
    assign b_op = ctrl_q.bsel ? imm_sext : b_shifted;

    // Overflow: operands (with B inverted for SUB) agree in sign but the result does not.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        alu_res = '0;
        alu_v   = 1'b0;
        unique case (ctrl_q.aluop)
            ALU_ADD: begin
                alu_res = a_op + b_op;
                alu_v   = (a_op[WIDTH-1] == b_op[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != a_op[WIDTH-1]);
            end
            ALU_SUB: begin
                alu_res = a_op - b_op;
                alu_v   = (a_op[WIDTH-1] != b_op[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != a_op[WIDTH-1]);
            end
            ALU_AND: alu_res = a_op & b_op;
            ALU_NOT: alu_res = ~b_op;
            default: alu_res = '0;
        endcase
    end

    assign alu_flags = {alu_res[WIDTH-1], alu_v, (alu_res == '0)};

    // mdata and pc are taken live in the WB cycle, not at start.
    always_comb begin
        unique case (ctrl_q.wb_sel)
            WB_MDATA: wb_data = mdata;
            WB_IMM:   wb_data = imm_sext;
            WB_PC:    wb_data = pc_zext;
            WB_C:     wb_data = c_q;
            default:  wb_data = c_q;
        endcase
    end

    assign wb_fire = (state_q == S_WB) && ctrl_q.wb_en && idx_valid(ctrl_q.rd);

    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        stat_d  = stat_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    ctrl_d = '{rn: rn, rm: rm, rd: rd,
                               shift: shift_t'(shift), aluop: aluop_t'(aluop),
                               asel: asel, bsel: bsel, setflags: setflags,
                               wb_sel: wb_sel_t'(wb_sel), wb_en: wb_en, imm: imm};
                    state_d = S_RDA;
                end
            end
            S_RDA: begin
                a_d     = rdata_a;
                state_d = S_RDB;
            end
            S_RDB: begin
                b_d     = rdata_b;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                c_d = alu_res;
                if (ctrl_q.setflags) begin
                    stat_d = alu_flags;
                end
                state_d = S_WB;
            end
            S_WB: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        regs_d = regs_q;
        if (wb_fire) begin
            regs_d[ctrl_q.rd] = wb_data;
        end
    end

    // NOTE: state is updated with non-blocking assignments only, so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ctrl_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            stat_q  <= '0;
            done_q  <= 1'b0;
            // NOTE: the register file is reset as a whole; it must read all-zero after
            // reset, so it is built from resettable flops rather than a RAM macro.
            regs_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            stat_q  <= stat_d;
            done_q  <= done_d;
            regs_q  <= regs_d;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign done         = done_q;
    assign stat         = stat_q;
    assign datapath_out = c_q;

endmodule

// File: tb/tb_seq_datapath.sv
// Bench for seq_datapath: directed corner cases plus random operations checked
// against an arithmetic reference model of the register file and status flags.
module tb_seq_datapath;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  rn, rm, rd, dbg_addr;
    logic [1:0]  shift, aluop, wb_sel;
    logic        asel, bsel, setflags, wb_en;
    logic [7:0]  imm;
    logic [15:0] mdata;
    logic [7:0]  pc;
    logic        busy, done;
    logic [2:0]  stat;
    logic [15:0] datapath_out, dbg_data;

    int n_vectors     = 0;
    int n_miscompares = 0;

    typedef struct packed {
        logic [2:0] rn, rm, rd;
        logic [1:0] shift, aluop;
        logic       asel, bsel, setflags;
        logic [1:0] wb_sel;
        logic       wb_en;
        logic [7:0] imm;
    } op_t;

    int         m_regs [8];
    int         m_c;
    logic [2:0] m_stat;

    seq_datapath dut (
        .clk(clk), .reset(reset), .start(start),
        .rn(rn), .rm(rm), .rd(rd), .shift(shift), .aluop(aluop),
        .asel(asel), .bsel(bsel), .setflags(setflags), .wb_sel(wb_sel),
        .wb_en(wb_en), .imm(imm), .mdata(mdata), .pc(pc), .dbg_addr(dbg_addr),
        .busy(busy), .done(done), .stat(stat),
        .datapath_out(datapath_out), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vectors++;
        assert (obs === exp) else begin
            n_miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int to16(input int x);
        return ((x % 65536) + 65536) % 65536;
    endfunction

    function automatic int to_signed(input int u);
        return (u >= 32768) ? u - 65536 : u;
    endfunction

    // Reference: plain integer arithmetic on the architectural effect of one operation.
    function automatic void model_exec(input op_t op, input int md, input int pcv);
        int a, b, bs, sb, bop, imm_s, s, r, v, wbv;
        a     = op.asel ? 0 : m_regs[op.rn];
        b     = m_regs[op.rm];
        sb    = to_signed(b);
        imm_s = (int'(op.imm) >= 128) ? int'(op.imm) - 256 : int'(op.imm);
        case (op.shift)
            2'd0: bs = b;
            2'd1: bs = to16(b * 2);
            2'd2: bs = b / 2;
            default: bs = to16((sb < 0) ? (sb - 1) / 2 : sb / 2);
        endcase
        bop = op.bsel ? to16(imm_s) : bs;
        v = 0;
        case (op.aluop)
            2'd0: begin s = to_signed(a) + to_signed(bop); r = to16(s); v = int'(s > 32767 || s < -32768); end
            2'd1: begin s = to_signed(a) - to_signed(bop); r = to16(s); v = int'(s > 32767 || s < -32768); end
            2'd2: r = a & bop;
            default: r = 65535 - bop;
        endcase
        m_c = r;
        if (op.setflags) m_stat = {r >= 32768, v != 0, r == 0};
        case (op.wb_sel)
            2'd0: wbv = md;
            2'd1: wbv = to16(imm_s);
            2'd2: wbv = pcv;
            default: wbv = r;
        endcase
        if (op.wb_en) m_regs[op.rd] = wbv;
    endfunction

    task automatic drive(input op_t op);
        rn = op.rn; rm = op.rm; rd = op.rd; shift = op.shift; aluop = op.aluop;
        asel = op.asel; bsel = op.bsel; setflags = op.setflags;
        wb_sel = op.wb_sel; wb_en = op.wb_en; imm = op.imm;
    endtask

    task automatic scramble();
        rn = 3'($urandom); rm = 3'($urandom); rd = 3'($urandom);
        shift = 2'($urandom); aluop = 2'($urandom); wb_sel = 2'($urandom);
        asel = 1'($urandom); bsel = 1'($urandom); setflags = 1'($urandom);
        wb_en = 1'($urandom); imm = 8'($urandom);
    endtask

    task automatic check_reg(input string tag, input int idx);
        dbg_addr = 3'(idx);
        #1;
        check(tag, dbg_data, m_regs[idx]);
    endtask

    // One full operation: start edge, done latency, C/stat/Rd, then done drop.
    task automatic run_op(input string tag, input op_t op, input logic [15:0] md, input logic [7:0] pcv);
        int n;
        drive(op);
        mdata = md; pc = pcv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        scramble();
        check({tag, "_busy"}, busy, 1);
        n = 0;
        while (!done && n < 12) begin
            @(posedge clk); #1;
            n++;
        end
        model_exec(op, md, pcv);
        check({tag, "_done_lat"}, n, 4);
        check({tag, "_c"}, datapath_out, m_c);
        check({tag, "_stat"}, stat, m_stat);
        check_reg({tag, "_rd"}, op.rd);
        @(posedge clk); #1;
        check({tag, "_done_drop"}, {busy, done}, 2'b00);
    endtask

    task automatic load_reg(input int idx, input logic [15:0] val);
        op_t op;
        op = '{rn: 0, rm: 0, rd: 3'(idx), shift: 0, aluop: 0, asel: 0, bsel: 0,
               setflags: 0, wb_sel: 2'b00, wb_en: 1, imm: 0};
        run_op("load", op, val, 8'h00);
    endtask

    initial begin
        op_t op;
        int  cnt, first, second;
        reset = 1'b1; start = 1'b0; mdata = '0; pc = '0; dbg_addr = '0;
        scramble();
        for (int i = 0; i < 8; i++) m_regs[i] = 0;
        m_c = 0; m_stat = 3'b000;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_flags", {busy, done, stat}, 5'b0);
        check("rst_out", datapath_out, 16'h0000);

        // Reset landing in EXEC aborts the operation.
        load_reg(2, 16'h1234);
        load_reg(5, 16'hBEEF);
        op = '{rn: 2, rm: 5, rd: 7, shift: 0, aluop: 0, asel: 0, bsel: 0,
               setflags: 1, wb_sel: 2'b11, wb_en: 1, imm: 0};
        drive(op); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        check("midrst_flags", {busy, done, stat}, 5'b0);
        check("midrst_out", datapath_out, 16'h0000);
        for (int i = 0; i < 8; i++) m_regs[i] = 0;
        m_c = 0; m_stat = 3'b000;
        for (int i = 0; i < 8; i++) check_reg("midrst_reg", i);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done) cnt++;
        end
        check("midrst_no_done", cnt, 0);

        // Immediate writeback, stat untouched.
        op = '{rn: 0, rm: 0, rd: 3, shift: 0, aluop: 0, asel: 0, bsel: 0,
               setflags: 0, wb_sel: 2'b01, wb_en: 1, imm: 8'hFB};
        run_op("imm_wb", op, 16'h5555, 8'h11);
        check_reg("imm_wb_r3", 3);
        check("imm_wb_r3_const", dbg_data, 16'hFFFB);
        check("imm_wb_stat", stat, 3'b000);

        // Signed overflow on ADD.
        load_reg(1, 16'h7FFF);
        load_reg(2, 16'h0001);
        op = '{rn: 1, rm: 2, rd: 4, shift: 0, aluop: 0, asel: 0, bsel: 0,
               setflags: 1, wb_sel: 2'b11, wb_en: 1, imm: 0};
        run_op("add_ovf", op, 16'h0, 8'h0);
        check("add_ovf_r4", dbg_data, 16'h8000);
        check("add_ovf_stat", stat, 3'b110);

        // ASR1 and LSR1 on B with A forced to zero.
        load_reg(5, 16'h8001);
        op = '{rn: 3, rm: 5, rd: 6, shift: 2'b11, aluop: 0, asel: 1, bsel: 0,
               setflags: 0, wb_sel: 2'b11, wb_en: 1, imm: 0};
        run_op("asr", op, 16'h0, 8'h0);
        check("asr_c", datapath_out, 16'hC000);
        op.shift = 2'b10;
        run_op("lsr", op, 16'h0, 8'h0);
        check("lsr_c", datapath_out, 16'h4000);

        // Compare-style SUB with a stray start while busy.
        op = '{rn: 1, rm: 1, rd: 6, shift: 0, aluop: 2'b01, asel: 0, bsel: 0,
               setflags: 1, wb_sel: 2'b11, wb_en: 0, imm: 0};
        drive(op); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) cnt++;
        end
        model_exec(op, 0, 0);
        check("cmp_one_done", cnt, 1);
        check("cmp_stat", stat, 3'b001);
        check_reg("cmp_r6", 6);

        // Start held for ten cycles: two dependent ops, R1 += 1 twice.
        load_reg(1, 16'h00F0);
        op = '{rn: 1, rm: 0, rd: 1, shift: 0, aluop: 0, asel: 0, bsel: 1,
               setflags: 1, wb_sel: 2'b11, wb_en: 1, imm: 8'h01};
        drive(op); start = 1'b1;
        cnt = 0; first = -1; second = -1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            if (i == 9) start = 1'b0;
            if (done) begin
                cnt++;
                if (first < 0) first = i; else if (second < 0) second = i;
            end
        end
        model_exec(op, 0, 0);
        model_exec(op, 0, 0);
        check("b2b_count", cnt, 2);
        check("b2b_spacing", second - first, 5);
        check("b2b_first", first, 4);
        check_reg("b2b_r1", 1);
        check("b2b_r1_const", dbg_data, 16'h00F2);

        // Random operations against the model.
        for (int t = 0; t < 40; t++) begin
            op = '{rn: 3'($urandom), rm: 3'($urandom), rd: 3'($urandom),
                   shift: 2'($urandom), aluop: 2'($urandom), asel: 1'($urandom),
                   bsel: 1'($urandom), setflags: 1'($urandom), wb_sel: 2'($urandom),
                   wb_en: 1'($urandom), imm: 8'($urandom)};
            run_op("rand", op, 16'($urandom), 8'($urandom));
        end
        for (int i = 0; i < 8; i++) check_reg("final_reg", i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
